// File: rtl/replacer_cnt_gen.sv
// replacer_cnt_gen: turns a stream of increasing, frame-relative bit positions
// into the byte-wide skip/insert count entries consumed by replacer_sign.
// Each position yields zero or more 0x7F skip entries followed by one
// {1, gap} sign-insert entry.
module replacer_cnt_gen #(
  parameter int POS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             frame_start,
  input  logic [POS_W-1:0] pos_in,
  input  logic             pos_empty,
  output logic             pos_rd,
  input  logic             cnt_full,
  output logic [7:0]       cnt_out,
  output logic             cnt_wr,
  output logic             order_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    CALC   = 3'd2,
    SKIP   = 3'd3,
    INSERT = 3'd4
  } state_t;

  // Largest gap a single entry can describe (7-bit field).
  localparam logic [POS_W-1:0] RUN_MAX = POS_W'(127);

  state_t           state_q, state_d;
  logic [POS_W-1:0] cur_q, cur_d;
  logic [POS_W-1:0] pos_reg_q, pos_reg_d;
  logic [POS_W-1:0] delta_q, delta_d;
  logic             pend_q, pend_d;
  logic             order_err_q, order_err_d;
  logic [7:0]       cnt_out_q, cnt_out_d;
  logic             cnt_wr_q, cnt_wr_d;

  logic             frame_req;
  logic             pos_late;
  logic [POS_W-1:0] calc_delta;
  logic [POS_W-1:0] skip_rem;

  assign frame_req  = pend_q | frame_start;
  assign pos_late   = pos_reg_q < cur_q;
  assign calc_delta = pos_reg_q - cur_q;
  assign skip_rem   = delta_q - RUN_MAX;

  // State register; a stall freezes the FSM, reset (active-low) returns it to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!frame_req && !pos_empty) state_d = FETCH;
      end
      FETCH: state_d = CALC;
      CALC: begin
        if (pos_late)                 state_d = IDLE;
        else if (calc_delta > RUN_MAX) state_d = SKIP;
        else                           state_d = INSERT;
      end
      SKIP: begin
        if (!cnt_full && (skip_rem <= RUN_MAX)) state_d = INSERT;
      end
      INSERT: begin
        if (!cnt_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs: FIFO read strobe and busy flag.
  always_comb begin
    pos_rd = rst && clk_en && (state_q == IDLE) && !frame_req && !pos_empty;
    busy   = (state_q != IDLE);
  end

  // Datapath next values: cursor, captured position, remaining gap, entry outputs.
  always_comb begin
    cur_d       = cur_q;
    pos_reg_d   = pos_reg_q;
    delta_d     = delta_q;
    pend_d      = pend_q;
    order_err_d = order_err_q;
    cnt_out_d   = cnt_out_q;
    cnt_wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          cur_d  = '0;
          pend_d = 1'b0;
        end
      end
      FETCH: begin
        pos_reg_d = pos_in;
      end
      CALC: begin
        if (pos_late) order_err_d = 1'b1;
        else          delta_d     = calc_delta;
      end
      SKIP: begin
        if (!cnt_full) begin
          cnt_wr_d  = 1'b1;
          cnt_out_d = 8'h7F;
          delta_d   = skip_rem;
          cur_d     = cur_q + RUN_MAX;
        end
      end
      INSERT: begin
        if (!cnt_full) begin
          cnt_wr_d  = 1'b1;
          cnt_out_d = {1'b1, delta_q[6:0]};
          cur_d     = pos_reg_q + POS_W'(1);
        end
      end
      default: ;
    endcase
    // A new frame seen mid-position waits until the position completes.
    if ((state_q != IDLE) && frame_start) pend_d = 1'b1;
  end

  // Datapath and registered outputs; the write strobe never repeats across a stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q       <= '0;
      pos_reg_q   <= '0;
      delta_q     <= '0;
      pend_q      <= 1'b0;
      order_err_q <= 1'b0;
      cnt_out_q   <= 8'h00;
      cnt_wr_q    <= 1'b0;
    end else if (clk_en) begin
      cur_q       <= cur_d;
      pos_reg_q   <= pos_reg_d;
      delta_q     <= delta_d;
      pend_q      <= pend_d;
      order_err_q <= order_err_d;
      cnt_out_q   <= cnt_out_d;
      cnt_wr_q    <= cnt_wr_d;
    end else begin
      cnt_wr_q    <= 1'b0;
    end
  end

  assign cnt_out   = cnt_out_q;
  assign cnt_wr    = cnt_wr_q;
  assign order_err = order_err_q;

endmodule

// File: tb/tb_replacer_cnt_gen.sv
// Directed bench for replacer_cnt_gen: a small position-FIFO model feeds the
// DUT, a monitor records every cnt entry with its cycle number, and the
// expected byte sequences are hand-computed.
module tb_replacer_cnt_gen;

  localparam int POS_W = 24;

  logic             clk;
  logic             rst;
  logic             clk_en;
  logic             frame_start;
  logic [POS_W-1:0] pos_in;
  logic             pos_empty;
  logic             pos_rd;
  logic             cnt_full;
  logic [7:0]       cnt_out;
  logic             cnt_wr;
  logic             order_err;
  logic             busy;

  replacer_cnt_gen #(.POS_W(POS_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .frame_start (frame_start),
    .pos_in      (pos_in),
    .pos_empty   (pos_empty),
    .pos_rd      (pos_rd),
    .cnt_full    (cnt_full),
    .cnt_out     (cnt_out),
    .cnt_wr      (cnt_wr),
    .order_err   (order_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position FIFO model
  logic [POS_W-1:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign pos_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (pos_rd) begin
      pos_in <= fifo_mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Write monitor, sampled just after the active edge
  logic [7:0] cap     [0:1023];
  int         cap_cyc [0:1023];
  int         ncap = 0;
  int         cyc  = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (cnt_wr === 1'b1) begin
      cap[ncap]     = cnt_out;
      cap_cyc[ncap] = cyc;
      ncap          = ncap + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    @(negedge clk);
    fifo_mem[wr_ptr % 64] = POS_W'(v);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while (!(pos_empty && !busy && !pos_rd) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_first_write(input int base);
    int k;
    k = 0;
    while (ncap == base && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_caps(input string tag, input int base, input int n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b [0:2];
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    check({tag, "_count"}, 32'(ncap - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < ncap) check($sformatf("%s_b%0d", tag, i), 32'(cap[base + i]), 32'(exp_b[i]));
    end
  endtask

  int base;

  initial begin
    rst         = 1'b0;
    clk_en      = 1'b1;
    frame_start = 1'b0;
    cnt_full    = 1'b0;
    repeat (4) @(negedge clk);

    // reset state
    check("rst_pos_rd",    32'(pos_rd),    32'd0);
    check("rst_cnt_wr",    32'(cnt_wr),    32'd0);
    check("rst_cnt_out",   32'(cnt_out),   32'h00);
    check("rst_order_err", 32'(order_err), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // positions 0,5,6 then 7 proves the cursor sits at 7
    base = ncap;
    push(0); push(5); push(6);
    wait_idle();
    chk_caps("basic", base, 3, 8'h80, 8'h84, 8'h80);
    check("basic_order_err", 32'(order_err), 32'd0);
    base = ncap;
    push(7);
    wait_idle();
    chk_caps("cur7", base, 1, 8'h80, 8'h00, 8'h00);

    // 300 from cursor 0: two skips then insert, back to back
    pulse_frame();
    base = ncap;
    push(300);
    wait_idle();
    chk_caps("p300", base, 3, 8'h7F, 8'h7F, 8'hAE);
    if (ncap - base == 3) begin
      check("p300_gap1", 32'(cap_cyc[base+1] - cap_cyc[base]),   32'd1);
      check("p300_gap2", 32'(cap_cyc[base+2] - cap_cyc[base+1]), 32'd1);
    end
    base = ncap;
    push(301);
    wait_idle();
    chk_caps("cur301", base, 1, 8'h80, 8'h00, 8'h00);

    // 300 with cnt_full held for 5 cycles during SKIP
    pulse_frame();
    base = ncap;
    push(300);
    wait_first_write(base);
    cnt_full = 1'b1;
    repeat (5) @(negedge clk);
    cnt_full = 1'b0;
    wait_idle();
    chk_caps("bp300", base, 3, 8'h7F, 8'h7F, 8'hAE);
    if (ncap - base == 3) begin
      check("bp300_gap1", 32'(cap_cyc[base+1] - cap_cyc[base]),   32'd6);
      check("bp300_gap2", 32'(cap_cyc[base+2] - cap_cyc[base+1]), 32'd1);
    end

    // out-of-order position is dropped and flags a sticky error
    pulse_frame();
    base = ncap;
    push(10); push(4);
    wait_idle();
    chk_caps("ord", base, 1, 8'h8A, 8'h00, 8'h00);
    check("ord_err_set", 32'(order_err), 32'd1);
    base = ncap;
    push(20);
    wait_idle();
    chk_caps("ord_next", base, 1, 8'h89, 8'h00, 8'h00);
    check("ord_err_sticky", 32'(order_err), 32'd1);

    // fresh reset, then frame_start during FETCH of position 3
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk); rst = 1'b1;
    check("rst2_order_err", 32'(order_err), 32'd0);
    base = ncap;
    push(10);
    wait_idle();
    chk_caps("fs_a", base, 1, 8'h8A, 8'h00, 8'h00);
    base = ncap;
    push(3);
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    wait_idle();
    check("fs_err", 32'(order_err), 32'd1);
    check("fs_nowrite", 32'(ncap - base), 32'd0);
    base = ncap;
    push(3);
    wait_idle();
    chk_caps("fs_b", base, 1, 8'h83, 8'h00, 8'h00);

    // reset asserted during SKIP of position 400
    base = ncap;
    push(400);
    wait_first_write(base);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_cnt_wr",    32'(cnt_wr),    32'd0);
    check("mrst_cnt_out",   32'(cnt_out),   32'h00);
    check("mrst_order_err", 32'(order_err), 32'd0);
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_pos_rd",    32'(pos_rd),    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_writes", 32'(ncap - base), 32'd1);
    base = ncap;
    push(2);
    wait_idle();
    chk_caps("mrst_after", base, 1, 8'h82, 8'h00, 8'h00);

    // clk_en low for 3 cycles mid-SKIP; a frame_start during the stall is ignored
    pulse_frame();
    base = ncap;
    push(300);
    wait_first_write(base);
    clk_en      = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    clk_en = 1'b1;
    wait_idle();
    chk_caps("stall300", base, 3, 8'h7F, 8'h7F, 8'hAE);
    if (ncap - base == 3)
      check("stall300_gap1", 32'(cap_cyc[base+1] - cap_cyc[base]), 32'd4);
    base = ncap;
    push(301);
    wait_idle();
    chk_caps("stall_fs_ignored", base, 1, 8'h80, 8'h00, 8'h00);

    // gap boundaries: delta 127 and delta 254
    pulse_frame();
    base = ncap;
    push(127);
    wait_idle();
    chk_caps("d127", base, 1, 8'hFF, 8'h00, 8'h00);
    pulse_frame();
    base = ncap;
    push(254);
    wait_idle();
    chk_caps("d254", base, 2, 8'h7F, 8'hFF, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
